// File: rtl/dac_wave_ctrl_if.sv
// Configuration write port for dac_wave_ctrl: valid/ready handshake carrying
// target channel, waveform mode, step/level and tick divider.
interface dac_wave_ctrl_if #(
  parameter int CH_W  = 1,
  parameter int DAC_W = 8,
  parameter int DIV_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_mode;
  logic [DAC_W-1:0] cfg_step;
  logic [DIV_W-1:0] cfg_div;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_step, cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_step, cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/dac_wave_ctrl.sv
// Multi-channel DAC waveform controller: each channel runs HOLD, SAW, TRI or SQR
// at its own step and tick period; config writes always override a pending tick.
module dac_wave_ctrl #(
  parameter int DAC_W = 8,
  parameter int DIV_W = 8,
  parameter int NCH   = 2,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  dac_wave_ctrl_if.slave       cfg,
  output logic [NCH*DAC_W-1:0] dac_code,
  output logic [NCH-1:0]       upd
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_SAW  = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_SQR  = 2'd3
  } mode_e;

  localparam logic [DAC_W-1:0] L_MAX   = {DAC_W{1'b1}};
  localparam logic [DAC_W-1:0] L_ZERO  = {DAC_W{1'b0}};
  localparam logic [DIV_W-1:0] L_CNT0  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] L_CNT1  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic r_ready;
  logic w_wr;

  assign w_wr          = cfg.cfg_valid & r_ready;
  assign cfg.cfg_ready = r_ready;

  // Ready rises on the first edge after reset and drops for the commit cycle of each write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= ~w_wr;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam logic [CH_W-1:0] L_CH = CH_W'(k);

    mode_e            r_mode;
    logic [DAC_W-1:0] r_step;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [DAC_W-1:0] r_code;
    logic             r_dn;
    logic             r_upd;

    logic             w_sel;
    logic             w_tick;
    logic [DAC_W:0]   w_sum;
    logic [DAC_W-1:0] w_nxt_code;
    logic             w_nxt_dn;

    // Out-of-range channel numbers never match, so such writes are silently dropped
    assign w_sel  = w_wr & (cfg.cfg_ch == L_CH);
    assign w_tick = ena & (r_cnt == r_div);
    assign w_sum  = {1'b0, r_code} + {1'b0, r_step};

    // Code and direction this channel would take on its next tick
    always_comb begin
      w_nxt_code = r_code;
      w_nxt_dn   = r_dn;
      case (r_mode)
        MODE_HOLD: begin
          w_nxt_code = r_code;
        end
        MODE_SAW: begin
          w_nxt_code = w_sum[DAC_W-1:0];
        end
        MODE_TRI: begin
          if (!r_dn) begin
            if (w_sum >= {1'b0, L_MAX}) begin
              w_nxt_code = L_MAX;
              w_nxt_dn   = 1'b1;
            end else begin
              w_nxt_code = w_sum[DAC_W-1:0];
              w_nxt_dn   = 1'b0;
            end
          end else begin
            if (r_code <= r_step) begin
              w_nxt_code = L_ZERO;
              w_nxt_dn   = 1'b0;
            end else begin
              w_nxt_code = r_code - r_step;
              w_nxt_dn   = 1'b1;
            end
          end
        end
        MODE_SQR: begin
          w_nxt_code = (r_code == L_ZERO) ? L_MAX : L_ZERO;
        end
        default: begin
          w_nxt_code = r_code;
        end
      endcase
    end

    // Channel state: a write wins over a same-edge tick; upd only on a real code change
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mode <= MODE_HOLD;
        r_step <= L_ZERO;
        r_div  <= L_CNT0;
        r_cnt  <= L_CNT0;
        r_code <= L_ZERO;
        r_dn   <= 1'b0;
        r_upd  <= 1'b0;
      end else if (w_sel) begin
        r_mode <= mode_e'(cfg.cfg_mode);
        r_step <= cfg.cfg_step;
        r_div  <= cfg.cfg_div;
        r_cnt  <= L_CNT0;
        r_code <= (mode_e'(cfg.cfg_mode) == MODE_HOLD) ? cfg.cfg_step : L_ZERO;
        r_dn   <= 1'b0;
        r_upd  <= 1'b0;
      end else if (w_tick) begin
        r_cnt  <= L_CNT0;
        r_code <= w_nxt_code;
        r_dn   <= w_nxt_dn;
        r_upd  <= (w_nxt_code != r_code);
      end else if (ena) begin
        r_cnt  <= r_cnt + L_CNT1;
        r_upd  <= 1'b0;
      end else begin
        r_upd  <= 1'b0;
      end
    end

    assign dac_code[k*DAC_W +: DAC_W] = r_code;
    assign upd[k]                     = r_upd;
  end

endmodule

// File: tb/tb_dac_wave_ctrl.sv
// Scoreboard bench for dac_wave_ctrl: stimulus pushes expected (cycle, channel, code)
// strobe events; a negedge monitor pops and compares whenever upd is seen.
module tb_dac_wave_ctrl;
  localparam int HOLD = 0;
  localparam int SAW  = 1;
  localparam int TRI  = 2;
  localparam int SQR  = 3;

  typedef struct {
    int         cyc;
    int         ch;
    logic [7:0] code;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [15:0] dac_code;
  logic [1:0]  upd;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q[$];

  dac_wave_ctrl_if #(.CH_W(2), .DAC_W(8), .DIV_W(8)) ifc ();

  dac_wave_ctrl #(.DAC_W(8), .DIV_W(8), .NCH(2), .CH_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .cfg      (ifc),
    .dac_code (dac_code),
    .upd      (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic push(input int c, input int ch, input logic [7:0] code);
    exp_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.code = code;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    int b;
    b = 0;
    while (cyc < n && b < 1000) begin
      @(negedge clk);
      b++;
    end
    chk("wait_cyc", cyc, n);
  endtask

  // Issue one write; at>0 pins the accepting edge, otherwise first ready edge
  task automatic wr(input int ch, input int m, input int s, input int d, input int at, output int e);
    int b;
    b = 0;
    @(negedge clk);
    while ((cyc < at - 1 || !ifc.cfg_ready) && b < 500) begin
      @(negedge clk);
      b++;
    end
    chk("wr_ready", ifc.cfg_ready, 1);
    if (at > 0) chk("wr_edge", cyc + 1, at);
    ifc.cfg_valid = 1'b1;
    ifc.cfg_ch    = 2'(ch);
    ifc.cfg_mode  = 2'(m);
    ifc.cfg_step  = 8'(s);
    ifc.cfg_div   = 8'(d);
    e = cyc + 1;
    @(negedge clk);
    ifc.cfg_valid = 1'b0;
    chk("ready_commit", ifc.cfg_ready, 0);
  endtask

  // Scoreboard monitor: every upd strobe must match a queued expectation
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (upd[k]) begin
        int idx;
        idx = -1;
        for (int i = 0; i < q.size(); i++) begin
          if (idx < 0 && q[i].ch == k) idx = i;
        end
        if (idx < 0) begin
          chk($sformatf("upd_unexpected_ch%0d", k), upd[k], 1'b0);
        end else begin
          chk($sformatf("upd_cycle_ch%0d", k), cyc, q[idx].cyc);
          chk($sformatf("upd_code_ch%0d", k), dac_code[k*8 +: 8], q[idx].code);
          q.delete(idx);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2;
    rst_n         = 1'b0;
    ena           = 1'b1;
    ifc.cfg_valid = 1'b0;
    ifc.cfg_ch    = 2'd0;
    ifc.cfg_mode  = 2'd0;
    ifc.cfg_step  = 8'd0;
    ifc.cfg_div   = 8'd0;

    // Reset state and first ready edge
    repeat (3) @(negedge clk);
    chk("rst_code", dac_code, 16'h0000);
    chk("rst_upd", upd, 2'b00);
    chk("rst_ready", ifc.cfg_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", ifc.cfg_ready, 1);

    // SAW wrap, div=0; stopped by a write that collides with the due tick
    wr(0, SAW, 8'h60, 0, -1, e);
    chk("saw_load", dac_code[7:0], 8'h00);
    push(e + 1, 0, 8'h60);
    push(e + 2, 0, 8'hC0);
    push(e + 3, 0, 8'h20);
    push(e + 4, 0, 8'h80);
    wr(0, HOLD, 0, 0, e + 5, e2);
    chk("saw_stop_upd", upd, 2'b00);

    // TRI turnaround, div=1
    wr(1, TRI, 8'h50, 1, -1, e);
    chk("tri_load", dac_code[15:8], 8'h00);
    push(e + 2,  1, 8'h50);
    push(e + 4,  1, 8'hA0);
    push(e + 6,  1, 8'hF0);
    push(e + 8,  1, 8'hFF);
    push(e + 10, 1, 8'hAF);
    push(e + 12, 1, 8'h5F);
    push(e + 14, 1, 8'h0F);
    push(e + 16, 1, 8'h00);
    push(e + 18, 1, 8'h50);
    wr(1, HOLD, 0, 0, e + 20, e2);
    chk("tri_stop_code", dac_code[15:8], 8'h00);

    // SQR div=3 on ch0, back-to-back HOLD write on ch1
    wr(0, SQR, 8'h00, 3, -1, e);
    wr(1, HOLD, 8'h3C, 0, -1, e2);
    chk("b2b_edge", e2, e + 2);
    chk("hold_level", dac_code[15:8], 8'h3C);
    push(e + 4,  0, 8'hFF);
    push(e + 8,  0, 8'h00);
    push(e + 12, 0, 8'hFF);
    push(e + 16, 0, 8'h00);
    wr(0, HOLD, 0, 0, e + 20, e2);
    chk("hold_steady", dac_code[15:8], 8'h3C);

    // ena pause: drop 2 cycles after a tick for 10 cycles
    wr(0, SAW, 8'h10, 4, -1, e);
    push(e + 5,  0, 8'h10);
    push(e + 10, 0, 8'h20);
    wait_cyc(e + 12);
    ena = 1'b0;
    wait_cyc(e + 22);
    chk("pause_frozen", dac_code[7:0], 8'h20);
    ena = 1'b1;
    push(e + 25, 0, 8'h30);
    wr(0, HOLD, 0, 0, e + 30, e2);

    // Collision: write lands on the edge the tick is due; ch1 untouched
    wr(0, SAW, 8'h20, 1, -1, e);
    push(e + 2, 0, 8'h20);
    wr(0, SAW, 8'h08, 0, e + 4, e2);
    chk("coll_upd", upd, 2'b00);
    chk("coll_code", dac_code[7:0], 8'h00);
    push(e + 5, 0, 8'h08);
    push(e + 6, 0, 8'h10);
    wr(0, HOLD, 8'h55, 0, e + 7, e2);
    chk("coll_final", dac_code, 16'h3C55);

    // Out-of-range channel write is accepted and discarded
    wr(3, HOLD, 8'hAA, 0, -1, e);
    @(negedge clk);
    chk("ch3_ignored", dac_code, 16'h3C55);

    // Asynchronous reset mid-waveform
    wr(0, SAW, 8'h11, 0, -1, e);
    push(e + 1, 0, 8'h11);
    push(e + 2, 0, 8'h22);
    wait_cyc(e + 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_code", dac_code, 16'h0000);
    chk("async_rst_upd", upd, 2'b00);
    repeat (3) @(negedge clk);
    chk("rst_hold_ready", ifc.cfg_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_ready", ifc.cfg_ready, 1);
    chk("rerelease_code", dac_code, 16'h0000);

    repeat (5) @(negedge clk);
    chk("sb_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
